prism_aux_bank: RTL



---
 rtl/prism_aux_pkg.sv | 21 ++
 rtl/prism_aux_counter.sv | 48 ++++
 rtl/prism_aux_bank.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prism_aux_pkg.sv
// Shared register map, field offsets and widths for the PRISM auxiliary resource bank.
package prism_aux_pkg;

    localparam logic [5:0] ADDR_CTRL     = 6'h00;
    localparam logic [5:0] ADDR_STATUS   = 6'h04;
    localparam logic [5:0] ADDR_SHIFT    = 6'h08;
    localparam logic [5:0] ADDR_SHCNT    = 6'h0C;
    localparam logic [5:0] ADDR_CNT_BASE = 6'h10;

    localparam int CTRL_RELOAD_LSB  = 0;
    localparam int CTRL_IRQ_EN_LSB  = 8;
    localparam int CTRL_SH_DIR_BIT  = 16;
    localparam int CTRL_SH_IRQ_BIT   = 17;
    localparam int CTRL_CASCADE_LSB = 24;

    localparam int STATUS_CNT_LSB = 0;
    localparam int STATUS_SH_BIT  = 16;

    localparam int SHCNT_W = 6;

endpackage

// File: rtl/prism_aux_counter.sv
// One countdown counter with preload register, one-shot/auto-reload mode and a
// registered reload pulse that keeps the zero flag visible for a cycle after a reload.
module prism_aux_counter
    import prism_aux_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             dec,
    input  logic             load,
    input  logic             reload_mode,
    input  logic             preload_wr,
    input  logic [CNT_W-1:0] preload_wdata,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             cnt_event
);

    logic [CNT_W-1:0] preload;
    logic             reload_pulse;

    assign cnt_event = run & dec & ~load & (count == CNT_W'(1));
    assign zero      = (count == '0) | reload_pulse;

    // A preload write coinciding with a load lands after the load has sampled the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            preload      <= '0;
            count        <= '0;
            reload_pulse <= 1'b0;
        end else begin
            if (preload_wr) begin
                preload <= preload_wdata;
            end
            reload_pulse <= cnt_event & reload_mode;
            if (run & load & ~dec) begin
                count <= preload;
            end else if (cnt_event) begin
                count <= reload_mode ? preload : '0;
            end else if (run & dec & ~load & (count != '0)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/prism_aux_bank.sv
// PRISM auxiliary bank: NUM_CNT countdown counters, one serial shifter, status/irq and bus regs.
// Optional counter chaining is compiled in with PRISM_AUX_CASCADE_EN.
module prism_aux_bank
    import prism_aux_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 24,
    parameter int SHIFT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fsm_run,
    input  logic [NUM_CNT-1:0] cnt_dec,
    input  logic [NUM_CNT-1:0] cnt_load,
    input  logic               sh_strobe,
    input  logic               sh_in,
    input  logic [5:0]         reg_addr,
    input  logic               reg_wr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic [NUM_CNT-1:0] cnt_zero,
    output logic               sh_out,
    output logic               sh_done,
    output logic               irq
);

    logic [NUM_CNT-1:0] ctrl_reload;
    logic [NUM_CNT-1:0] ctrl_irq_en;
    logic               ctrl_sh_dir;
    logic               ctrl_sh_irq_en;
`ifdef PRISM_AUX_CASCADE_EN
    logic [NUM_CNT-1:0] ctrl_cascade;
`endif

    logic [NUM_CNT-1:0] status_cnt;
    logic               status_sh;

    logic [SHIFT_W-1:0] sh_data;
    logic [SHIFT_W-1:0] sh_next;
    logic [SHCNT_W-1:0] sh_rem;
    logic [SHCNT_W-1:0] sh_rem_wval;
    logic               shift_go;
    logic               sh_event;

    logic [NUM_CNT-1:0] cnt_event;
    logic [NUM_CNT-1:0] cnt_dec_eff;
    logic [CNT_W-1:0]   count [NUM_CNT];

    logic               wr_ctrl;
    logic               wr_status;
    logic               wr_shift;
    logic               wr_shcnt;
    logic [NUM_CNT-1:0] clr_cnt;
    logic               clr_sh;
    logic               unused_wdata;

    assign wr_ctrl   = reg_wr & (reg_addr == ADDR_CTRL);
    assign wr_status = reg_wr & (reg_addr == ADDR_STATUS);
    assign wr_shift  = reg_wr & (reg_addr == ADDR_SHIFT);
    assign wr_shcnt  = reg_wr & (reg_addr == ADDR_SHCNT);

    assign clr_cnt = wr_status ? reg_wdata[STATUS_CNT_LSB +: NUM_CNT] : '0;
    assign clr_sh  = wr_status & reg_wdata[STATUS_SH_BIT];

    assign unused_wdata = ^reg_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reload    <= '0;
            ctrl_irq_en    <= '0;
            ctrl_sh_dir    <= 1'b0;
            ctrl_sh_irq_en <= 1'b0;
`ifdef PRISM_AUX_CASCADE_EN
            ctrl_cascade   <= '0;
`endif
        end else if (wr_ctrl) begin
            ctrl_reload    <= reg_wdata[CTRL_RELOAD_LSB +: NUM_CNT];
            ctrl_irq_en    <= reg_wdata[CTRL_IRQ_EN_LSB +: NUM_CNT];
            ctrl_sh_dir    <= reg_wdata[CTRL_SH_DIR_BIT];
            ctrl_sh_irq_en <= reg_wdata[CTRL_SH_IRQ_BIT];
`ifdef PRISM_AUX_CASCADE_EN
            ctrl_cascade   <= reg_wdata[CTRL_CASCADE_LSB +: NUM_CNT];
`endif
        end
    end

`ifdef PRISM_AUX_CASCADE_EN
    // Chain walks upward so counter k sees counter k-1's event in the same cycle; cascade[0] is ignored.
    always_comb begin
        logic ev_prev;
        cnt_dec_eff = cnt_dec;
        ev_prev     = 1'b0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if ((k > 0) && ctrl_cascade[k]) begin
                cnt_dec_eff[k] = ev_prev;
            end
            ev_prev = fsm_run & cnt_dec_eff[k] & ~cnt_load[k] & (count[k] == CNT_W'(1));
        end
    end
`else
    assign cnt_dec_eff = cnt_dec;
`endif

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        localparam logic [5:0] CNT_ADDR = ADDR_CNT_BASE + 6'(4 * k);

        prism_aux_counter #(
            .CNT_W(CNT_W)
        ) u_counter (
            .clk          (clk),
            .rst          (rst),
            .run          (fsm_run),
            .dec          (cnt_dec_eff[k]),
            .load         (cnt_load[k]),
            .reload_mode  (ctrl_reload[k]),
            .preload_wr   (reg_wr & (reg_addr == CNT_ADDR)),
            .preload_wdata(reg_wdata[CNT_W-1:0]),
            .count        (count[k]),
            .zero         (cnt_zero[k]),
            .cnt_event    (cnt_event[k])
        );
    end

    assign sh_rem_wval = (reg_wdata[SHCNT_W-1:0] > SHCNT_W'(SHIFT_W)) ? SHCNT_W'(SHIFT_W)
                                                                      : reg_wdata[SHCNT_W-1:0];
    assign shift_go    = fsm_run & sh_strobe & (sh_rem != '0) & ~wr_shift & ~wr_shcnt;
    assign sh_event    = shift_go & (sh_rem == SHCNT_W'(1));
    assign sh_next     = ctrl_sh_dir ? {sh_in, sh_data[SHIFT_W-1:1]}
                                     : {sh_data[SHIFT_W-2:0], sh_in};

    // A bus write to SHIFT or SHCNT pre-empts any strobe in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data <= '0;
            sh_rem  <= '0;
        end else begin
            if (wr_shift) begin
                sh_data <= reg_wdata[SHIFT_W-1:0];
            end else if (shift_go) begin
                sh_data <= sh_next;
            end
            if (wr_shcnt) begin
                sh_rem <= sh_rem_wval;
            end else if (shift_go) begin
                sh_rem <= sh_rem - SHCNT_W'(1);
            end
        end
    end

    assign sh_out  = ctrl_sh_dir ? sh_data[0] : sh_data[SHIFT_W-1];
    assign sh_done = (sh_rem == '0);

    // Set beats clear; irq follows the registered status by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_cnt <= '0;
            status_sh  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            status_cnt <= (status_cnt & ~clr_cnt) | cnt_event;
            status_sh  <= (status_sh & ~clr_sh) | sh_event;
            irq        <= (|(status_cnt & ctrl_irq_en)) | (status_sh & ctrl_sh_irq_en);
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_addr == ADDR_CTRL) begin
            reg_rdata[CTRL_RELOAD_LSB +: NUM_CNT]  = ctrl_reload;
            reg_rdata[CTRL_IRQ_EN_LSB +: NUM_CNT]  = ctrl_irq_en;
            reg_rdata[CTRL_SH_DIR_BIT]             = ctrl_sh_dir;
            reg_rdata[CTRL_SH_IRQ_BIT]             = ctrl_sh_irq_en;
`ifdef PRISM_AUX_CASCADE_EN
            reg_rdata[CTRL_CASCADE_LSB +: NUM_CNT] = ctrl_cascade;
`endif
        end else if (reg_addr == ADDR_STATUS) begin
            reg_rdata[STATUS_CNT_LSB +: NUM_CNT] = status_cnt;
            reg_rdata[STATUS_SH_BIT]             = status_sh;
        end else if (reg_addr == ADDR_SHIFT) begin
            reg_rdata[SHIFT_W-1:0] = sh_data;
        end else if (reg_addr == ADDR_SHCNT) begin
            reg_rdata[SHCNT_W-1:0] = sh_rem;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                if (reg_addr == ADDR_CNT_BASE + 6'(4 * k)) begin
                    reg_rdata[CNT_W-1:0] = count[k];
                end
            end
        end
    end

endmodule
